// File: rtl/iq_ctrl_pkg.sv
// Shared types for the hop scheduler: FSM encoding and datapath width helpers.
package iq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_DWELL  = 2'd3
    } hop_state_t;

    localparam int ACCUMULATOR_WIDTH_DEF = 32;
    localparam int INCR_WIDTH_DEF        = ACCUMULATOR_WIDTH_DEF - 1;
    localparam int DWELL_WIDTH_DEF       = 16;

    // The DDS increment is one bit narrower than its accumulator.
    function automatic int incr_width(input int acc_width);
        return acc_width - 1;
    endfunction

endpackage

// File: rtl/hop_table.sv
// Hop table: DEPTH entries of (increment, dwell); synchronous write, combinational read.
// Latency: read is 0 cycles; a write lands on the next edge, so a same-cycle read sees the old value.
// Backpressure: none; writes are always accepted.
module hop_table #(
    parameter int DEPTH_LOG2 = 3,
    parameter int INCR_W     = 31,
    parameter int DWELL_W    = 16
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [INCR_W-1:0]     wr_incr,
    input  logic [DWELL_W-1:0]    wr_dwell,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [INCR_W-1:0]     rd_incr,
    output logic [DWELL_W-1:0]    rd_dwell
);

    logic [INCR_W-1:0]  incr_mem  [2**DEPTH_LOG2];
    logic [DWELL_W-1:0] dwell_mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            incr_mem[wr_addr]  <= wr_incr;
            dwell_mem[wr_addr] <= wr_dwell;
        end
    end

    assign rd_incr  = incr_mem[rd_addr];
    assign rd_dwell = dwell_mem[rd_addr];

endmodule

// File: rtl/iq_hop_sched.sv
// Frequency-hop scheduler: steps a table of DDS increments, blanking SETTLE samples after each hop.
// Latency: start -> LOAD next edge -> new increment visible one edge later (o_hop marks it).
// Backpressure: none; progress is paced only by i_ce, i_stop aborts from any state.
module iq_hop_sched
    import iq_ctrl_pkg::*;
#(
    parameter int ACCUMULATOR_WIDTH = ACCUMULATOR_WIDTH_DEF,
    parameter int DEPTH_LOG2        = 3,
    parameter int DWELL_WIDTH       = DWELL_WIDTH_DEF,
    parameter int SETTLE            = 4
) (
    input  logic                         i_clk,
    input  logic                         i_reset_n,
    input  logic                         i_ce,
    input  logic                         i_wr_en,
    input  logic [DEPTH_LOG2-1:0]        i_wr_addr,
    input  logic [ACCUMULATOR_WIDTH-2:0] i_wr_incr,
    input  logic [DWELL_WIDTH-1:0]       i_wr_dwell,
    input  logic [DEPTH_LOG2-1:0]        i_last_idx,
    input  logic                         i_loop,
    input  logic                         i_start,
    input  logic                         i_stop,
    output logic [ACCUMULATOR_WIDTH-2:0] o_increment,
    output logic                         o_valid,
    output logic                         o_busy,
    output logic [DEPTH_LOG2-1:0]        o_index,
    output logic                         o_hop,
    output logic                         o_done
);

    localparam int IW = incr_width(ACCUMULATOR_WIDTH);
    localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    hop_state_t             state;
    logic [DWELL_WIDTH-1:0] dwell_cnt;
    logic [SW-1:0]          settle_cnt;
    logic [IW-1:0]          rd_incr;
    logic [DWELL_WIDTH-1:0] rd_dwell;

    hop_table #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .INCR_W     (IW),
        .DWELL_W    (DWELL_WIDTH)
    ) u_table (
        .clk      (i_clk),
        .wr_en    (i_wr_en),
        .wr_addr  (i_wr_addr),
        .wr_incr  (i_wr_incr),
        .wr_dwell (i_wr_dwell),
        .rd_addr  (o_index),
        .rd_incr  (rd_incr),
        .rd_dwell (rd_dwell)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= ST_IDLE;
            o_increment <= '0;
            o_index     <= '0;
            o_hop       <= 1'b0;
            o_done      <= 1'b0;
            dwell_cnt   <= '0;
            settle_cnt  <= '0;
        end else begin
            o_hop  <= 1'b0;
            o_done <= 1'b0;
            if (i_stop) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (i_start) begin
                            o_index <= '0;
                            state   <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        o_increment <= rd_incr;
                        // A zero dwell would otherwise underflow; it still yields one sample.
                        dwell_cnt   <= (rd_dwell == '0) ? DWELL_WIDTH'(1) : rd_dwell;
                        settle_cnt  <= SW'(SETTLE);
                        o_hop       <= 1'b1;
                        state       <= (SETTLE > 0) ? ST_SETTLE : ST_DWELL;
                    end
                    ST_SETTLE: begin
                        if (i_ce) begin
                            if (settle_cnt == SW'(1)) state <= ST_DWELL;
                            else                      settle_cnt <= settle_cnt - SW'(1);
                        end
                    end
                    ST_DWELL: begin
                        if (i_ce) begin
                            if (dwell_cnt == DWELL_WIDTH'(1)) begin
                                if (o_index != i_last_idx) begin
                                    o_index <= o_index + DEPTH_LOG2'(1);
                                    state   <= ST_LOAD;
                                end else if (i_loop) begin
                                    o_index <= '0;
                                    state   <= ST_LOAD;
                                end else begin
                                    o_done  <= 1'b1;
                                    state   <= ST_IDLE;
                                end
                            end else begin
                                dwell_cnt <= dwell_cnt - DWELL_WIDTH'(1);
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign o_busy  = (state != ST_IDLE);
    assign o_valid = (state == ST_DWELL) && i_ce;

endmodule

// File: tb/tb_iq_hop_sched.sv
// Directed bench for iq_hop_sched: SETTLE=2 main instance plus a SETTLE=0 instance for start latency.
module tb_iq_hop_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce, wr_en, loop_en, start, stop;
    logic [2:0]  wr_addr, last_idx;
    logic [30:0] wr_incr;
    logic [15:0] wr_dwell;

    logic [30:0] inc, inc0;
    logic        valid, busy, hop, done, valid0, busy0, hop0, done0;
    logic [2:0]  idx, idx0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    iq_hop_sched #(.ACCUMULATOR_WIDTH(32), .DEPTH_LOG2(3), .DWELL_WIDTH(16), .SETTLE(2)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_ce(ce), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
        .i_wr_incr(wr_incr), .i_wr_dwell(wr_dwell), .i_last_idx(last_idx), .i_loop(loop_en),
        .i_start(start), .i_stop(stop), .o_increment(inc), .o_valid(valid), .o_busy(busy),
        .o_index(idx), .o_hop(hop), .o_done(done)
    );

    iq_hop_sched #(.ACCUMULATOR_WIDTH(32), .DEPTH_LOG2(3), .DWELL_WIDTH(16), .SETTLE(0)) dut0 (
        .i_clk(clk), .i_reset_n(rst_n), .i_ce(ce), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
        .i_wr_incr(wr_incr), .i_wr_dwell(wr_dwell), .i_last_idx(last_idx), .i_loop(loop_en),
        .i_start(start), .i_stop(stop), .o_increment(inc0), .o_valid(valid0), .o_busy(busy0),
        .o_index(idx0), .o_hop(hop0), .o_done(done0)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input logic [2:0] a, input logic [30:0] i, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_incr = i; wr_dwell = d;
        step;
        wr_en = 1'b0;
    endtask

    task automatic write_std_table;
        write_entry(3'd0, 31'h100, 16'd4);
        write_entry(3'd1, 31'h200, 16'd2);
        write_entry(3'd2, 31'h300, 16'd1);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int c = 0; c < 4; c++) begin
            ce = c[0];
            step;
        end
        checks++;
        if ({inc, idx, busy, hop, done, valid} !== 39'd0) begin
            errors++;
            $display("FAIL reset_outputs got inc=%h idx=%0d busy=%b hop=%b done=%b valid=%b exp all 0",
                     inc, idx, busy, hop, done, valid);
        end
        rst_n = 1'b1;
        ce = 1'b1;
        step; step; step;
        checks++;
        if ({inc, idx, busy, hop, done, valid} !== 39'd0) begin
            errors++;
            $display("FAIL post_reset_idle got inc=%h idx=%0d busy=%b hop=%b done=%b valid=%b exp all 0",
                     inc, idx, busy, hop, done, valid);
        end
    endtask

    task automatic test_latency;
        last_idx = 3'd0; loop_en = 1'b0; ce = 1'b1;
        start = 1'b1;
        step;
        start = 1'b0;
        checks++;
        if (valid0 !== 1'b0) begin
            errors++;
            $display("FAIL latency_load_cycle got valid=%b exp 0", valid0);
        end
        step;
        checks++;
        if (valid0 !== 1'b1 || hop0 !== 1'b1 || inc0 !== 31'h100) begin
            errors++;
            $display("FAIL latency_first_valid got valid=%b hop=%b inc=%h exp 1 1 100", valid0, hop0, inc0);
        end
        stop = 1'b1;
        step;
        stop = 1'b0;
    endtask

    task automatic test_seq;
        int hops = 0, dones = 0, blank = 0, bad_blank = 0, cyc = 0;
        int v100 = 0, v200 = 0, v300 = 0;
        logic seen_hop = 1'b0;
        logic [30:0] hop_inc [3];
        last_idx = 3'd2; loop_en = 1'b0; ce = 1'b1;
        start = 1'b1;
        step;
        start = 1'b0;
        while (cyc < 40 && dones == 0) begin
            if (hop) begin
                if (hops < 3) hop_inc[hops] = inc;
                hops++;
                blank = 0;
                seen_hop = 1'b1;
            end
            if (valid) begin
                if (seen_hop) begin
                    if (blank != 2) bad_blank++;
                    seen_hop = 1'b0;
                end
                if (inc == 31'h100) v100++;
                else if (inc == 31'h200) v200++;
                else if (inc == 31'h300) v300++;
            end else if (busy && seen_hop) begin
                blank++;
            end
            if (done) dones++;
            cyc++;
            step;
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL seq_done_count got %0d exp 1", dones);
        end
        checks++;
        if (hops != 3 || hop_inc[0] !== 31'h100 || hop_inc[1] !== 31'h200 || hop_inc[2] !== 31'h300) begin
            errors++;
            $display("FAIL seq_hops got n=%0d %h %h %h exp 3 100 200 300", hops, hop_inc[0], hop_inc[1], hop_inc[2]);
        end
        checks++;
        if (v100 != 4 || v200 != 2 || v300 != 1) begin
            errors++;
            $display("FAIL seq_valid_runs got %0d/%0d/%0d exp 4/2/1", v100, v200, v300);
        end
        checks++;
        if (bad_blank != 0) begin
            errors++;
            $display("FAIL seq_settle_blank got %0d bad windows exp 0", bad_blank);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || inc !== 31'h300) begin
            errors++;
            $display("FAIL seq_end_state got busy=%b done=%b inc=%h exp 0 0 300", busy, done, inc);
        end
    endtask

    task automatic test_loop;
        int hops = 0, dones = 0, cyc = 0;
        last_idx = 3'd2; loop_en = 1'b1; ce = 1'b1;
        start = 1'b1;
        step;
        start = 1'b0;
        while (cyc < 60 && hops < 4) begin
            if (done) dones++;
            if (hop) hops++;
            if (hops < 4) begin
                cyc++;
                step;
            end
        end
        checks++;
        if (hops != 4 || inc !== 31'h100 || idx !== 3'd0 || dones != 0) begin
            errors++;
            $display("FAIL loop_wrap got hops=%0d inc=%h idx=%0d dones=%0d exp 4 100 0 0", hops, inc, idx, dones);
        end
        cyc = 0;
        while (cyc < 10 && !valid) begin
            cyc++;
            step;
        end
        checks++;
        if (valid !== 1'b1) begin
            errors++;
            $display("FAIL loop_reach_dwell got valid=%b exp 1 (timeout)", valid);
        end
        stop = 1'b1;
        step;
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || valid !== 1'b0 || inc !== 31'h100) begin
            errors++;
            $display("FAIL stop_dwell got busy=%b done=%b valid=%b inc=%h exp 0 0 0 100", busy, done, valid, inc);
        end
        step;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stop_no_done got done=%b busy=%b exp 0 0", done, busy);
        end
    endtask

    task automatic test_dwell0;
        int valids = 0, first_valid = -1, done_at = -1;
        write_entry(3'd0, 31'h80, 16'd0);
        last_idx = 3'd0; loop_en = 1'b0;
        for (int c = 0; c < 30; c++) begin
            ce = (c % 3 == 0);
            start = (c == 0);
            #1;
            if (valid) begin
                valids++;
                if (first_valid < 0) first_valid = c;
            end
            if (done && done_at < 0) done_at = c;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        checks++;
        if (valids != 1 || first_valid != 9) begin
            errors++;
            $display("FAIL dwell0_valid got count=%0d at=%0d exp 1 at 9", valids, first_valid);
        end
        checks++;
        if (done_at != 10 || inc !== 31'h80) begin
            errors++;
            $display("FAIL dwell0_done got done_at=%0d inc=%h exp 10 80", done_at, inc);
        end
    endtask

    task automatic test_start_stop;
        ce = 1'b1;
        start = 1'b1; stop = 1'b1;
        step;
        start = 1'b0; stop = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_stop_same got busy=%b exp 0", busy);
        end
        step; step;
        checks++;
        if (busy !== 1'b0 || hop !== 1'b0 || inc !== 31'h80) begin
            errors++;
            $display("FAIL start_stop_idle got busy=%b hop=%b inc=%h exp 0 0 80", busy, hop, inc);
        end
    endtask

    task automatic test_start_busy;
        int cyc = 0;
        write_entry(3'd0, 31'h100, 16'd4);
        last_idx = 3'd2; loop_en = 1'b0; ce = 1'b1;
        start = 1'b1;
        step;
        start = 1'b0;
        while (cyc < 10 && !valid) begin
            cyc++;
            step;
        end
        start = 1'b1;
        step;
        start = 1'b0;
        checks++;
        if (idx !== 3'd0 || valid !== 1'b1 || busy !== 1'b1 || inc !== 31'h100 || hop !== 1'b0) begin
            errors++;
            $display("FAIL start_while_busy got idx=%0d valid=%b busy=%b inc=%h hop=%b exp 0 1 1 100 0",
                     idx, valid, busy, inc, hop);
        end
        stop = 1'b1;
        step;
        stop = 1'b0;
    endtask

    task automatic test_write_reset;
        int cyc = 0;
        last_idx = 3'd2; loop_en = 1'b0; ce = 1'b1;
        start = 1'b1;
        step;
        start = 1'b0;
        while (cyc < 10 && !valid) begin
            cyc++;
            step;
        end
        write_entry(3'd1, 31'h555, 16'd2);
        cyc = 0;
        while (cyc < 20 && !hop) begin
            cyc++;
            step;
        end
        checks++;
        if (hop !== 1'b1 || inc !== 31'h555 || idx !== 3'd1) begin
            errors++;
            $display("FAIL write_during_run got hop=%b inc=%h idx=%0d exp 1 555 1", hop, inc, idx);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({inc, idx, busy, hop, done, valid} !== 39'd0) begin
            errors++;
            $display("FAIL async_reset_settle got inc=%h idx=%0d busy=%b hop=%b done=%b valid=%b exp all 0",
                     inc, idx, busy, hop, done, valid);
        end
        step;
        rst_n = 1'b1;
        step;
    endtask

    initial begin
        rst_n = 1'b0; ce = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_incr = '0; wr_dwell = '0;
        last_idx = '0; loop_en = 1'b0; start = 1'b0; stop = 1'b0;
        test_reset;
        write_std_table;
        test_latency;
        test_seq;
        test_loop;
        test_dwell0;
        test_start_stop;
        test_start_busy;
        test_write_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
